// File: rtl/cgra_config_loader_if.sv
// Nibble command stream from the chip pins into the PE configuration loader.
// Latency: n/a (wires only).
// Backpressure: the loader drives in_ready; a nibble moves on a rising edge with in_valid && in_ready.
//
// Signals:
//   in_data  [3:0]  command/data nibble (master -> slave)
//   in_valid        in_data is valid     (master -> slave)
//   in_ready        slave can accept     (slave -> master)
interface cgra_config_loader_if;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cgra_config_loader.sv
// Host-side PE array writer: decodes a nibble command stream into per-PE control words and run bursts.
// Latency: all outputs registered; ctrl_out commits one edge after the last config nibble, pe_en rises the cycle after the count nibble.
// Backpressure: in_ready is low during EXEC and for the single commit cycle; a stalled frame simply waits.
//
// Ports:
//   clock, reset        single clock, async active-low reset
//   in_if (slave)       nibble stream: in_data / in_valid / in_ready
//   ctrl_out            NUM_PE packed 8-bit control words, PE i at [8i+7:8i]
//   op0_out, op1_out    operands broadcast to every PE
//   pe_en               broadcast enable, high for exactly N cycles per burst
//   busy / done / err   status: not IDLE / end-of-burst pulse / illegal command pulse
module cgra_config_loader #(
   parameter int NUM_PE = 4,
   parameter int CNT_W  = 8   // run length is loaded as two nibbles, so this stays 8
) (
   input  logic                    clock,
   input  logic                    reset,
   cgra_config_loader_if.slave     in_if,
   output logic [8*NUM_PE-1:0]     ctrl_out,
   output logic [3:0]              op0_out,
   output logic [3:0]              op1_out,
   output logic                    pe_en,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int IDX_W = $clog2(2*NUM_PE + 1);
   localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   // idx reaching this value marks the one-cycle commit phase of a CFG frame
   localparam logic [IDX_W-1:0] CFG_NIB = IDX_W'(2*NUM_PE);

   typedef enum logic [1:0] {IDLE, CFG, RUN_ARGS, EXEC} state_t;

   state_t                     state, state_nxt;
   logic [IDX_W-1:0]           idx, idx_nxt;
   logic [NUM_PE-1:0][7:0]     shadow, shadow_nxt;
   logic [8*NUM_PE-1:0]        ctrl_nxt;
   logic [3:0]                 op0_nxt, op1_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic                       pe_en_nxt, busy_nxt, done_nxt, err_nxt, rdy_nxt;
   logic                       accept;
   logic [PE_W-1:0]            pe_sel;

   assign accept = in_if.in_valid && in_if.in_ready;
   assign pe_sel = idx[PE_W:1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      shadow_nxt = shadow;
      ctrl_nxt   = ctrl_out;
      op0_nxt    = op0_out;
      op1_nxt    = op1_out;
      cnt_nxt    = cnt;
      pe_en_nxt  = 1'b0;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               case (in_if.in_data)
                  4'h0: ;
                  4'h1: begin state_nxt = CFG;      idx_nxt = '0; end
                  4'h2: begin state_nxt = RUN_ARGS; idx_nxt = '0; end
                  default: err_nxt = 1'b1;
               endcase
            end
         end
         CFG: begin
            if (idx == CFG_NIB) begin
               // every shadow word is complete: publish them in one step
               ctrl_nxt  = shadow;
               state_nxt = IDLE;
            end else if (accept) begin
               if (!idx[0]) shadow_nxt[pe_sel][7:4] = in_if.in_data;
               else         shadow_nxt[pe_sel][3:0] = in_if.in_data;
               idx_nxt = idx + IDX_W'(1);
            end
         end
         RUN_ARGS: begin
            if (accept) begin
               idx_nxt = idx + IDX_W'(1);
               case (idx[1:0])
                  2'd0: op0_nxt = in_if.in_data;
                  2'd1: op1_nxt = in_if.in_data;
                  2'd2: cnt_nxt = {in_if.in_data, 4'h0};
                  default: begin
                     cnt_nxt = {cnt[7:4], in_if.in_data};
                     if (cnt_nxt == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                     end else begin
                        pe_en_nxt = 1'b1;
                        state_nxt = EXEC;
                     end
                  end
               endcase
            end
         end
         EXEC: begin
            // cnt holds the number of enable cycles still to show, including this one
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               pe_en_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
      rdy_nxt  = (state_nxt != EXEC) && !((state_nxt == CFG) && (idx_nxt == CFG_NIB));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx            <= '0;
         shadow         <= '0;
         ctrl_out       <= '0;
         op0_out        <= '0;
         op1_out        <= '0;
         cnt            <= '0;
         pe_en          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         in_if.in_ready <= 1'b0;
      end else begin
         idx            <= idx_nxt;
         shadow         <= shadow_nxt;
         ctrl_out       <= ctrl_nxt;
         op0_out        <= op0_nxt;
         op1_out        <= op1_nxt;
         cnt            <= cnt_nxt;
         pe_en          <= pe_en_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         err            <= err_nxt;
         in_if.in_ready <= rdy_nxt;
      end
   end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Self-checking bench for cgra_config_loader: scripted frames, expected results queued at stimulus time.
// Latency: n/a.
// Backpressure: nibbles are held valid until the loader takes them, bounded by a cycle budget.
module tb_cgra_config_loader;
   localparam int NUM_PE = 4;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic [8*NUM_PE-1:0]   ctrl_out;
   logic [3:0]            op0_out, op1_out;
   logic                  pe_en, busy, done, err;

   cgra_config_loader_if in_if();

   cgra_config_loader #(.NUM_PE(NUM_PE), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .in_if(in_if),
      .ctrl_out(ctrl_out), .op0_out(op0_out), .op1_out(op1_out),
      .pe_en(pe_en), .busy(busy), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] cur_ctrl = '0;

   // Present one nibble until accepted; inputs change at negedge, acceptance is the following posedge.
   task automatic send(input logic [3:0] d);
      bit   acc = 1'b0;
      logic r;
      for (int i = 0; i < 600 && !acc; i++) begin
         @(negedge clock);
         in_if.in_valid = 1'b1;
         in_if.in_data  = d;
         r = in_if.in_ready;
         @(posedge clock);
         acc = r;
      end
      #1 in_if.in_valid = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL send_timeout nibble=%h never accepted", d);
      end
   endtask

   // Observe until ctrl_out moves away from prev (bounded), reporting what was seen.
   task automatic watch_commit(input logic [31:0] prev, output logic seen, output logic [31:0] val,
                               output logic busy_at, output logic rdy_at);
      seen = 1'b0; val = prev; busy_at = 1'b1; rdy_at = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clock);
         if (ctrl_out !== prev) begin
            seen = 1'b1; val = ctrl_out; busy_at = busy; rdy_at = in_if.in_ready;
         end
      end
   endtask

   // Observe a burst from the cycle after the count nibble until done (bounded), then one more cycle.
   task automatic watch_burst(input logic [31:0] c_ref, input logic [3:0] o0, input logic [3:0] o1,
                              output int n_en, output int done_at, output int rdy_viol, output int out_chg,
                              output logic rdy_done, output logic done_after, output logic busy_after,
                              output logic err_after);
      n_en = 0; done_at = -1; rdy_viol = 0; out_chg = 0; rdy_done = 1'b0;
      for (int cyc = 1; cyc <= 400 && done_at < 0; cyc++) begin
         @(negedge clock);
         if (pe_en === 1'b1) n_en++;
         if (ctrl_out !== c_ref || op0_out !== o0 || op1_out !== o1) out_chg++;
         if (done === 1'b1) begin
            done_at  = cyc;
            rdy_done = in_if.in_ready;
         end else if (in_if.in_ready !== 1'b0) begin
            rdy_viol++;
         end
      end
      @(posedge clock);
      #1 in_if.in_valid = 1'b0;
      @(negedge clock);
      done_after = done; busy_after = busy; err_after = err;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_if.in_valid = 1'b0;
      in_if.in_data  = 4'h0;
      repeat (3) @(negedge clock);
      checks++; if (in_if.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_if.in_ready); end
      checks++; if ({pe_en, busy, done, err} !== 4'b0) begin failures++; $display("FAIL rst_status got=%b exp=0000", {pe_en, busy, done, err}); end
      checks++; if (ctrl_out !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", ctrl_out); end
      checks++; if ({op0_out, op1_out} !== 8'h0) begin failures++; $display("FAIL rst_ops got=%h exp=00", {op0_out, op1_out}); end
      reset = 1'b1;
      @(negedge clock);
      checks++; if (in_if.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_if.in_ready); end
   endtask

   task automatic test_config();
      logic [3:0]  nib [8] = '{4'hA, 4'h5, 4'h3, 4'hC, 4'hF, 4'h0, 4'h0, 4'h9};
      logic        seen, b_at, r_at;
      logic [31:0] val, exp;
      send(4'h1);
      @(negedge clock);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cfg_busy got=%b exp=1", busy); end
      exp_q.push_back(32'h09F03CA5);
      for (int i = 0; i < 8; i++) begin
         send(nib[i]);
         if (i < 7) begin
            @(negedge clock);
            checks++; if (ctrl_out !== cur_ctrl) begin failures++; $display("FAIL cfg_no_partial nib=%0d got=%h exp=%h", i, ctrl_out, cur_ctrl); end
            repeat (i % 3) @(negedge clock);
         end
      end
      watch_commit(cur_ctrl, seen, val, b_at, r_at);
      exp = exp_q.pop_front();
      checks++; if (seen !== 1'b1 || val !== exp) begin failures++; $display("FAIL cfg_commit got=%h exp=%h", val, exp); end
      checks++; if (b_at !== 1'b0 || r_at !== 1'b1) begin failures++; $display("FAIL cfg_commit_status busy=%b ready=%b exp busy=0 ready=1", b_at, r_at); end
      cur_ctrl = exp;
   endtask

   task automatic test_burst();
      int   n_en, done_at, rv, oc, exp;
      logic rd, da, ba, ea;
      send(4'h2); send(4'h7);
      @(negedge clock);
      checks++; if (op0_out !== 4'h7) begin failures++; $display("FAIL burst_op0 got=%h exp=7", op0_out); end
      send(4'h3);
      @(negedge clock);
      checks++; if (op1_out !== 4'h3) begin failures++; $display("FAIL burst_op1 got=%h exp=3", op1_out); end
      send(4'h0); send(4'h5);
      exp_q.push_back(32'd5);
      watch_burst(cur_ctrl, 4'h7, 4'h3, n_en, done_at, rv, oc, rd, da, ba, ea);
      exp = int'(exp_q.pop_front());
      checks++; if (n_en != exp) begin failures++; $display("FAIL burst_len got=%0d exp=%0d", n_en, exp); end
      checks++; if (done_at != exp + 1) begin failures++; $display("FAIL burst_done_cycle got=%0d exp=%0d", done_at, exp + 1); end
      checks++; if (rv != 0 || rd !== 1'b1) begin failures++; $display("FAIL burst_ready viol=%0d ready_at_done=%b exp 0/1", rv, rd); end
      checks++; if (oc != 0) begin failures++; $display("FAIL burst_outputs_stable changes=%0d exp=0", oc); end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin failures++; $display("FAIL burst_after done=%b busy=%b exp 0/0", da, ba); end
   endtask

   task automatic test_zero_count();
      int   n_en, done_at, rv, oc, exp;
      logic rd, da, ba, ea;
      send(4'h2); send(4'h1); send(4'h1); send(4'h0); send(4'h0);
      exp_q.push_back(32'd0);
      watch_burst(cur_ctrl, 4'h1, 4'h1, n_en, done_at, rv, oc, rd, da, ba, ea);
      exp = int'(exp_q.pop_front());
      checks++; if (n_en != exp) begin failures++; $display("FAIL zero_pe_en got=%0d exp=%0d", n_en, exp); end
      checks++; if (done_at != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", done_at); end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin failures++; $display("FAIL zero_after done=%b busy=%b exp 0/0", da, ba); end
   endtask

   task automatic test_max_count();
      int   n_en, done_at, rv, oc, exp;
      logic rd, da, ba, ea;
      send(4'h2); send(4'h0); send(4'h0); send(4'hF); send(4'hF);
      exp_q.push_back(32'd255);
      // offer an illegal command during the burst; it must wait until done
      in_if.in_data  = 4'h9;
      in_if.in_valid = 1'b1;
      watch_burst(cur_ctrl, 4'h0, 4'h0, n_en, done_at, rv, oc, rd, da, ba, ea);
      exp = int'(exp_q.pop_front());
      checks++; if (n_en != exp) begin failures++; $display("FAIL max_len got=%0d exp=%0d", n_en, exp); end
      checks++; if (done_at != exp + 1) begin failures++; $display("FAIL max_done_cycle got=%0d exp=%0d", done_at, exp + 1); end
      checks++; if (rv != 0) begin failures++; $display("FAIL max_ready_in_exec count=%0d exp=0", rv); end
      checks++; if (ea !== 1'b1 || ba !== 1'b0) begin failures++; $display("FAIL max_pending_taken err=%b busy=%b exp 1/0", ea, ba); end
   endtask

   task automatic test_illegal();
      logic [3:0]  nib [8] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h0, 4'h0};
      logic        seen, b_at, r_at;
      logic [31:0] val, exp;
      @(negedge clock);
      send(4'h9);
      @(negedge clock);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL illegal_err err=%b busy=%b exp 1/0", err, busy); end
      checks++; if (ctrl_out !== cur_ctrl) begin failures++; $display("FAIL illegal_ctrl got=%h exp=%h", ctrl_out, cur_ctrl); end
      @(negedge clock);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_pulse_width err=%b exp=0", err); end
      send(4'h0);
      @(negedge clock);
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL nop err=%b busy=%b exp 0/0", err, busy); end
      // command-looking nibbles inside a frame are plain data, sent back to back
      send(4'h1);
      exp_q.push_back(32'h00112222);
      for (int i = 0; i < 8; i++) send(nib[i]);
      watch_commit(cur_ctrl, seen, val, b_at, r_at);
      exp = exp_q.pop_front();
      checks++; if (seen !== 1'b1 || val !== exp) begin failures++; $display("FAIL cfg_data_not_cmd got=%h exp=%h", val, exp); end
      cur_ctrl = exp;
   endtask

   task automatic test_reset_mid_exec();
      int   n_en, done_at, rv, oc, exp;
      logic rd, da, ba, ea;
      send(4'h2); send(4'h4); send(4'h5); send(4'hC); send(4'h8);
      repeat (10) @(negedge clock);
      checks++; if (pe_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL midexec_running pe_en=%b busy=%b exp 1/1", pe_en, busy); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({pe_en, busy, done, in_if.in_ready} !== 4'b0) begin failures++; $display("FAIL midexec_async_clear got=%b exp=0000", {pe_en, busy, done, in_if.in_ready}); end
      checks++; if (ctrl_out !== 32'h0 || op0_out !== 4'h0) begin failures++; $display("FAIL midexec_clear_data ctrl=%h op0=%h exp 0/0", ctrl_out, op0_out); end
      cur_ctrl = '0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++; if (in_if.in_ready !== 1'b1) begin failures++; $display("FAIL midexec_release_ready got=%b exp=1", in_if.in_ready); end
      send(4'h2); send(4'h6); send(4'h1); send(4'h0); send(4'h3);
      exp_q.push_back(32'd3);
      watch_burst(cur_ctrl, 4'h6, 4'h1, n_en, done_at, rv, oc, rd, da, ba, ea);
      exp = int'(exp_q.pop_front());
      checks++; if (n_en != exp || done_at != exp + 1) begin failures++; $display("FAIL midexec_fresh_burst len=%0d done_at=%0d exp %0d/%0d", n_en, done_at, exp, exp + 1); end
      checks++; if (oc != 0) begin failures++; $display("FAIL midexec_fresh_outputs changes=%0d exp=0", oc); end
   endtask

   initial begin
      in_if.in_valid = 1'b0;
      in_if.in_data  = 4'h0;
      test_reset();
      test_config();
      test_burst();
      test_zero_count();
      test_max_count();
      test_illegal();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
